// File: rtl/mem_sequencer.sv
// Memory-access sequencer: takes one word request from the multicycle control FSM,
// presents it to the unified memory for a fixed latency, and returns done/IR/MDR strobes.
module mem_sequencer #(
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic        Clk,
    input  logic        Reset_signal,
    input  logic        req,
    input  logic        wr,
    input  logic        IorD,
    input  logic [31:0] PC,
    input  logic [31:0] ALUOut,
    input  logic [31:0] B,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr,
    output logic        busy,
    output logic        done,
    output logic        align_fault,
    output logic        IR_load,
    output logic        MDR_load,
    output logic [31:0] rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        FAULT  = 2'd3
    } state_t;

    localparam logic [3:0] RD_INIT = 4'(READ_LATENCY - 1);
    localparam logic [3:0] WR_INIT = 4'(WRITE_LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        op_q, op_d;
    logic        src_q, src_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_wr_q, mem_wr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        align_fault_q, align_fault_d;
    logic        ir_load_q, ir_load_d;
    logic        mdr_load_q, mdr_load_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] addr_sel_s;

    assign addr_sel_s = IorD ? ALUOut : PC;

    // Next-state and next-output logic; outputs are computed for the state being entered
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        src_d         = src_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_wr_d      = mem_wr_q;
        busy_d        = busy_q;
        rdata_d       = rdata_q;
        done_d        = 1'b0;
        align_fault_d = 1'b0;
        ir_load_d     = 1'b0;
        mdr_load_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    busy_d = 1'b1;
                    if (addr_sel_s[1:0] != 2'b00) begin
                        state_d       = FAULT;
                        align_fault_d = 1'b1;
                        mem_wr_d      = 1'b0;
                    end else begin
                        state_d     = ACCESS;
                        mem_addr_d  = addr_sel_s;
                        mem_wdata_d = B;
                        mem_wr_d    = wr;
                        op_d        = wr;
                        src_d       = IorD;
                        cnt_d       = wr ? WR_INIT : RD_INIT;
                    end
                end else begin
                    busy_d   = 1'b0;
                    mem_wr_d = 1'b0;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d    = DONE;
                    mem_wr_d   = 1'b0;
                    done_d     = 1'b1;
                    ir_load_d  = ~op_q & ~src_q;
                    mdr_load_d = ~op_q & src_q;
                    if (!op_q) begin
                        rdata_d = mem_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                mem_wr_d = 1'b0;
            end
            FAULT: begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                mem_wr_d = 1'b0;
            end
            default: begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                mem_wr_d = 1'b0;
            end
        endcase
    end

    // State and registered-output update with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset_signal) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            op_q          <= 1'b0;
            src_q         <= 1'b0;
            mem_addr_q    <= 32'd0;
            mem_wdata_q   <= 32'd0;
            mem_wr_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            align_fault_q <= 1'b0;
            ir_load_q     <= 1'b0;
            mdr_load_q    <= 1'b0;
            rdata_q       <= 32'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            src_q         <= src_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_wr_q      <= mem_wr_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            align_fault_q <= align_fault_d;
            ir_load_q     <= ir_load_d;
            mdr_load_q    <= mdr_load_d;
            rdata_q       <= rdata_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wr      = mem_wr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign align_fault = align_fault_q;
    assign IR_load     = ir_load_q;
    assign MDR_load    = mdr_load_q;
    assign rdata       = rdata_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// Scoreboard bench for mem_sequencer: default-latency instance plus a READ_LATENCY=5 instance.
module tb_mem_sequencer;

    typedef struct {
        bit          fault;
        bit          ir;
        bit          mdr;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        req5 = 1'b0;
    logic        wr = 1'b0;
    logic        iord = 1'b0;
    logic [31:0] pc = 32'd0;
    logic [31:0] aluout = 32'd0;
    logic [31:0] b = 32'd0;
    logic [31:0] mem_rdata = 32'd0;

    logic [31:0] mem_addr, mem_wdata, rdata;
    logic        mem_wr, busy, done, align_fault, ir_load, mdr_load;
    logic [31:0] mem_addr5, mem_wdata5, rdata5;
    logic        mem_wr5, busy5, done5, align_fault5, ir_load5, mdr_load5;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   n;
    exp_t q[$];
    exp_t q5[$];
    exp_t e_main, e_5;
    logic [31:0] stream_data [3];

    mem_sequencer dut (
        .Clk(clk), .Reset_signal(rst), .req(req), .wr(wr), .IorD(iord),
        .PC(pc), .ALUOut(aluout), .B(b), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .busy(busy),
        .done(done), .align_fault(align_fault), .IR_load(ir_load), .MDR_load(mdr_load),
        .rdata(rdata)
    );

    mem_sequencer #(.READ_LATENCY(5), .WRITE_LATENCY(1)) dut5 (
        .Clk(clk), .Reset_signal(rst), .req(req5), .wr(wr), .IorD(iord),
        .PC(pc), .ALUOut(aluout), .B(b), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr5), .mem_wdata(mem_wdata5), .mem_wr(mem_wr5), .busy(busy5),
        .done(done5), .align_fault(align_fault5), .IR_load(ir_load5), .MDR_load(mdr_load5),
        .rdata(rdata5)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor for the default instance: every strobe must match the next scoreboard entry
    always @(negedge clk) begin
        if (done | align_fault | ir_load | mdr_load) begin
            if (q.size() == 0) begin
                chk("unexpected_strobe", {28'd0, done, align_fault, ir_load, mdr_load}, 32'd0);
            end else begin
                e_main = q.pop_front();
                chk("strobe_cycle", cyc, e_main.cyc);
                chk("done", {31'd0, done}, {31'd0, ~e_main.fault});
                chk("align_fault", {31'd0, align_fault}, {31'd0, e_main.fault});
                chk("IR_load", {31'd0, ir_load}, {31'd0, e_main.ir});
                chk("MDR_load", {31'd0, mdr_load}, {31'd0, e_main.mdr});
                chk("rdata", rdata, e_main.rdata);
            end
        end
    end

    // Monitor for the READ_LATENCY=5 instance
    always @(negedge clk) begin
        if (done5 | align_fault5 | ir_load5 | mdr_load5) begin
            if (q5.size() == 0) begin
                chk("unexpected_strobe_l5", {28'd0, done5, align_fault5, ir_load5, mdr_load5}, 32'd0);
            end else begin
                e_5 = q5.pop_front();
                chk("strobe_cycle_l5", cyc, e_5.cyc);
                chk("done_l5", {31'd0, done5}, {31'd0, ~e_5.fault});
                chk("IR_load_l5", {31'd0, ir_load5}, {31'd0, e_5.ir});
                chk("MDR_load_l5", {31'd0, mdr_load5}, {31'd0, e_5.mdr});
                chk("rdata_l5", rdata5, e_5.rdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        stream_data[0] = 32'h1111_0000;
        stream_data[1] = 32'h2222_0001;
        stream_data[2] = 32'h3333_0002;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk("reset_rdata", rdata, 32'd0);

        // Instruction fetch from PC; PC changes during access must not leak through
        tick(); n = cyc;
        req = 1'b1; wr = 1'b0; iord = 1'b0; pc = 32'h0000_0010; mem_rdata = 32'h8C22_0004;
        q.push_back('{fault: 1'b0, ir: 1'b1, mdr: 1'b0, rdata: 32'h8C22_0004, cyc: n + 3});
        tick(); req = 1'b0; pc = 32'hFFFF_FFF0;
        @(negedge clk);
        chk("fetch_addr_n1", mem_addr, 32'h0000_0010);
        chk("fetch_busy_n1", {31'd0, busy}, 32'd1);
        chk("fetch_wr_n1", {31'd0, mem_wr}, 32'd0);
        tick(); @(negedge clk);
        chk("fetch_addr_n2", mem_addr, 32'h0000_0010);
        tick(); tick(); @(negedge clk);
        chk("fetch_busy_n4", {31'd0, busy}, 32'd0);

        // Data write: one mem_wr cycle, rdata untouched
        tick(); n = cyc;
        req = 1'b1; wr = 1'b1; iord = 1'b1; aluout = 32'h0000_0100; b = 32'hDEAD_BEEF;
        q.push_back('{fault: 1'b0, ir: 1'b0, mdr: 1'b0, rdata: 32'h8C22_0004, cyc: n + 2});
        tick(); req = 1'b0; b = 32'h0; aluout = 32'h0000_0F00;
        @(negedge clk);
        chk("write_mem_wr_n1", {31'd0, mem_wr}, 32'd1);
        chk("write_addr_n1", mem_addr, 32'h0000_0100);
        chk("write_wdata_n1", mem_wdata, 32'hDEAD_BEEF);
        tick(); @(negedge clk);
        chk("write_mem_wr_n2", {31'd0, mem_wr}, 32'd0);
        tick(); @(negedge clk);
        chk("write_busy_n3", {31'd0, busy}, 32'd0);

        // Misaligned data read
        tick(); n = cyc;
        req = 1'b1; wr = 1'b0; iord = 1'b1; aluout = 32'h0000_0102; mem_rdata = 32'hBAD0_BAD0;
        q.push_back('{fault: 1'b1, ir: 1'b0, mdr: 1'b0, rdata: 32'h8C22_0004, cyc: n + 1});
        tick(); req = 1'b0;
        @(negedge clk);
        chk("fault_busy_n1", {31'd0, busy}, 32'd1);
        chk("fault_mem_wr_n1", {31'd0, mem_wr}, 32'd0);
        tick(); @(negedge clk);
        chk("fault_busy_n2", {31'd0, busy}, 32'd0);
        chk("fault_mem_wr_n2", {31'd0, mem_wr}, 32'd0);
        tick();

        // Back-to-back fetches with req held high: one access every 4 cycles
        tick(); n = cyc;
        req = 1'b1; wr = 1'b0; iord = 1'b0; pc = 32'h0000_0020; mem_rdata = stream_data[0];
        for (int k = 0; k < 3; k++) begin
            q.push_back('{fault: 1'b0, ir: 1'b1, mdr: 1'b0, rdata: stream_data[k], cyc: n + 4 * k + 3});
        end
        for (int k = 0; k < 3; k++) begin
            tick(); pc = 32'hAAAA_0000;
            @(negedge clk);
            chk("stream_addr_a", mem_addr, 32'h0000_0020 + 32'(4 * k));
            tick(); @(negedge clk);
            chk("stream_addr_b", mem_addr, 32'h0000_0020 + 32'(4 * k));
            tick(); tick();
            if (k < 2) begin
                pc = 32'h0000_0020 + 32'(4 * (k + 1));
                mem_rdata = stream_data[k + 1];
            end else begin
                req = 1'b0;
            end
        end
        repeat (3) tick();

        // Reset during the first access cycle of a read
        n = cyc;
        req = 1'b1; wr = 1'b0; iord = 1'b0; pc = 32'h0000_0040; mem_rdata = 32'h5555_5555;
        tick(); req = 1'b0; rst = 1'b1;
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        repeat (4) tick();
        @(negedge clk);
        chk("rst_busy_later", {31'd0, busy}, 32'd0);

        // READ_LATENCY=5 instance: data read
        tick(); n = cyc;
        req5 = 1'b1; wr = 1'b0; iord = 1'b1; aluout = 32'h0000_0200; mem_rdata = 32'h1234_5678;
        q5.push_back('{fault: 1'b0, ir: 1'b0, mdr: 1'b1, rdata: 32'h1234_5678, cyc: n + 6});
        for (int i = 1; i <= 5; i++) begin
            tick();
            req5 = 1'b0; aluout = 32'h0000_0F00;
            @(negedge clk);
            chk("l5_addr", mem_addr5, 32'h0000_0200);
            chk("l5_busy", {31'd0, busy5}, 32'd1);
        end
        tick(); tick(); @(negedge clk);
        chk("l5_busy_after", {31'd0, busy5}, 32'd0);
        repeat (3) tick();

        chk("pending_expected", 32'(q.size()), 32'd0);
        chk("pending_expected_l5", 32'(q5.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
